// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared EX/MEM packet layout.
// The packet is packed MSB-first as
//   new_pc, zero, overflow, alu_out, rw, mem_wr, branch, mem_to_reg, reg_wr, bus_b
// The helpers below return the packet width and the LSB offset of each field
// for a given DATA_W / RW_W. Both pipeline stages use them, so the layout is
// defined in exactly one place.
package ex_mem_pkg;

   function automatic int pkt_w(input int data_w, input int rw_w);
      return 3*data_w + rw_w + 6;
   endfunction

   function automatic int off_bus_b();
      return 0;
   endfunction

   function automatic int off_reg_wr(input int data_w);
      return data_w;
   endfunction

   function automatic int off_mem_to_reg(input int data_w);
      return data_w + 1;
   endfunction

   function automatic int off_branch(input int data_w);
      return data_w + 2;
   endfunction

   function automatic int off_mem_wr(input int data_w);
      return data_w + 3;
   endfunction

   function automatic int off_rw(input int data_w);
      return data_w + 4;
   endfunction

   function automatic int off_alu_out(input int data_w, input int rw_w);
      return data_w + rw_w + 4;
   endfunction

   function automatic int off_overflow(input int data_w, input int rw_w);
      return 2*data_w + rw_w + 4;
   endfunction

   function automatic int off_zero(input int data_w, input int rw_w);
      return 2*data_w + rw_w + 5;
   endfunction

   function automatic int off_new_pc(input int data_w, input int rw_w);
      return 2*data_w + rw_w + 6;
   endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// ex_mem_stage_if: valid/ready handshake on both sides of the EX/MEM register.
//   in_valid/in_ready/in_pkt    : upstream EX packet
//   out_valid/out_ready/out_pkt : downstream MEM packet
// slave  : view of the pipeline register itself
// master : view of the surrounding pipeline (EX producer + MEM consumer)
interface ex_mem_stage_if #(
   parameter int DATA_W = 32,
   parameter int RW_W   = 5
) ();
   import ex_mem_pkg::*;

   localparam int PKT_W = pkt_w(DATA_W, RW_W);

   logic             in_valid;
   logic             in_ready;
   logic [PKT_W-1:0] in_pkt;
   logic             out_valid;
   logic             out_ready;
   logic [PKT_W-1:0] out_pkt;

   modport slave (
      input  in_valid, in_pkt, out_ready,
      output in_ready, out_valid, out_pkt
   );

   modport master (
      output in_valid, in_pkt, out_ready,
      input  in_ready, out_valid, out_pkt
   );

endinterface

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with a two-entry skid buffer.
// Ports:
//   clk       pipeline clock, state updates on the falling edge
//   rst_n     asynchronous active-low reset
//   flush     drop held and incoming packets
//   bus       ex_mem_stage_if.slave handshake (in_* from EX, out_* to MEM)
//   occupancy number of packets held (0..2)
// in_ready is the registered inverse of skid_valid, so there is no
// combinational path from out_ready back to in_ready.
module ex_mem_stage
   import ex_mem_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int RW_W     = 5,
   parameter bit OVF_KILL = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   ex_mem_stage_if.slave         bus,
   output logic [1:0]            occupancy
);

   localparam int PKT_W        = pkt_w(DATA_W, RW_W);
   localparam int OFF_REG_WR   = off_reg_wr(DATA_W);
   localparam int OFF_BRANCH   = off_branch(DATA_W);
   localparam int OFF_MEM_WR   = off_mem_wr(DATA_W);
   localparam int OFF_OVERFLOW = off_overflow(DATA_W, RW_W);

   logic             main_valid_q, main_valid_d;
   logic             skid_valid_q, skid_valid_d;
   logic [PKT_W-1:0] main_pkt_q, main_pkt_d;
   logic [PKT_W-1:0] skid_pkt_q, skid_pkt_d;
   logic             accept;
   logic             load_main;
   logic [PKT_W-1:0] out_pkt;

   always_comb begin
      accept       = bus.in_valid & ~skid_valid_q & ~flush;
      load_main    = ~main_valid_q | bus.out_ready;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      main_pkt_d   = main_pkt_q;
      skid_pkt_d   = skid_pkt_q;

      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (load_main) begin
         if (skid_valid_q) begin
            main_pkt_d   = skid_pkt_q;
            main_valid_d = 1'b1;
         end else if (accept) begin
            main_pkt_d   = bus.in_pkt;
            main_valid_d = 1'b1;
         end else begin
            main_valid_d = 1'b0;
         end
         // Whenever skid drains into main, in_ready was low, so nothing can
         // be accepted on that edge and skid always ends up empty here.
         skid_valid_d = 1'b0;
      end else if (accept) begin
         skid_pkt_d   = bus.in_pkt;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         main_pkt_q   <= '0;
         skid_pkt_q   <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         main_pkt_q   <= main_pkt_d;
         skid_pkt_q   <= skid_pkt_d;
      end
   end

   // Side-effect controls are gated so a bubble can never write memory,
   // the register file or redirect the PC; data fields keep their last value.
   always_comb begin
      out_pkt = main_pkt_q;
      if (!main_valid_q) begin
         out_pkt[OFF_MEM_WR] = 1'b0;
         out_pkt[OFF_REG_WR] = 1'b0;
         out_pkt[OFF_BRANCH] = 1'b0;
      end
      if (OVF_KILL && main_pkt_q[OFF_OVERFLOW]) begin
         out_pkt[OFF_REG_WR] = 1'b0;
      end
   end

   assign bus.out_pkt   = out_pkt;
   assign bus.out_valid = main_valid_q;
   assign bus.in_ready  = ~skid_valid_q;
   assign occupancy     = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule
